// File: rtl/port_request_stager.sv
// port_request_stager: three independent request FIFOs that hold each
// head entry until the memory_banks_cluster accepts it (freeze_inputs=0).
// Ports: clk, reset_n (sync, active-low), freeze_inputs, flush,
//   per port N=1..3: client side portN_req_{valid,ready,tag,addr,data,wen},
//   cluster side portN_{req_tag_in,addr,data_in,wen,valid}, portN_count.
// Optional: define PORT_REQUEST_STAGER_STATS_EN to add freeze_stall_cycles.
module port_request_stager #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             freeze_inputs,
  input  logic             flush,
  input  logic             port1_req_valid,
  output logic             port1_req_ready,
  input  logic [1:0]       port1_req_tag,
  input  logic [11:0]      port1_req_addr,
  input  logic [15:0]      port1_req_data,
  input  logic             port1_req_wen,
  output logic [1:0]       port1_req_tag_in,
  output logic [11:0]      port1_addr,
  output logic [15:0]      port1_data_in,
  output logic             port1_wen,
  output logic             port1_valid,
  output logic [PTR_W:0]   port1_count,
  input  logic             port2_req_valid,
  output logic             port2_req_ready,
  input  logic [1:0]       port2_req_tag,
  input  logic [11:0]      port2_req_addr,
  input  logic [15:0]      port2_req_data,
  input  logic             port2_req_wen,
  output logic [1:0]       port2_req_tag_in,
  output logic [11:0]      port2_addr,
  output logic [15:0]      port2_data_in,
  output logic             port2_wen,
  output logic             port2_valid,
  output logic [PTR_W:0]   port2_count,
  input  logic             port3_req_valid,
  output logic             port3_req_ready,
  input  logic [1:0]       port3_req_tag,
  input  logic [11:0]      port3_req_addr,
  input  logic [15:0]      port3_req_data,
  input  logic             port3_req_wen,
  output logic [1:0]       port3_req_tag_in,
  output logic [11:0]      port3_addr,
  output logic [15:0]      port3_data_in,
  output logic             port3_wen,
  output logic             port3_valid,
  output logic [PTR_W:0]   port3_count
`ifdef PORT_REQUEST_STAGER_STATS_EN
  ,
  output logic [15:0]      freeze_stall_cycles
`endif
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  // Entry layout: {tag[30:29], addr[28:17], data[16:1], wen[0]}
  logic [30:0]      mem_q [3][DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [3];
  logic [PTR_W-1:0] wr_ptr_d [3];
  logic [PTR_W-1:0] rd_ptr_q [3];
  logic [PTR_W-1:0] rd_ptr_d [3];
  logic [PTR_W:0]   count_q [3];
  logic [PTR_W:0]   count_d [3];

  logic [2:0]  req_valid;
  logic [30:0] req_pkt [3];
  logic [2:0]  ready;
  logic [2:0]  valid;
  logic [2:0]  push;
  logic [2:0]  pop;
  logic [30:0] head [3];

  assign req_valid = {port3_req_valid, port2_req_valid, port1_req_valid};
  assign req_pkt[0] = {port1_req_tag, port1_req_addr,
                       port1_req_data, port1_req_wen};
  assign req_pkt[1] = {port2_req_tag, port2_req_addr,
                       port2_req_data, port2_req_wen};
  assign req_pkt[2] = {port3_req_tag, port3_req_addr,
                       port3_req_data, port3_req_wen};

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      ready[p] = (count_q[p] != FULL_CNT);
      valid[p] = (count_q[p] != '0);
      push[p]  = req_valid[p] & ready[p];
      // The cluster captures the head in any non-frozen cycle.
      pop[p]   = valid[p] & ~freeze_inputs;
      head[p]  = valid[p] ? mem_q[p][rd_ptr_q[p]] : '0;
      wr_ptr_d[p] = wr_ptr_q[p];
      rd_ptr_d[p] = rd_ptr_q[p];
      count_d[p]  = count_q[p];
      if (flush) begin
        wr_ptr_d[p] = '0;
        rd_ptr_d[p] = '0;
        count_d[p]  = '0;
      end else begin
        if (push[p]) wr_ptr_d[p] = wr_ptr_q[p] + 1'b1;
        if (pop[p])  rd_ptr_d[p] = rd_ptr_q[p] + 1'b1;
        unique case ({push[p], pop[p]})
          2'b10:   count_d[p] = count_q[p] + 1'b1;
          2'b01:   count_d[p] = count_q[p] - 1'b1;
          default: count_d[p] = count_q[p];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int p = 0; p < 3; p++) begin
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
        count_q[p]  <= '0;
      end
    end else begin
      for (int p = 0; p < 3; p++) begin
        wr_ptr_q[p] <= wr_ptr_d[p];
        rd_ptr_q[p] <= rd_ptr_d[p];
        count_q[p]  <= count_d[p];
      end
    end
  end

  // Storage is deliberately left without reset.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 3; p++) begin
      if (push[p] && !flush) mem_q[p][wr_ptr_q[p]] <= req_pkt[p];
    end
  end

  assign port1_req_ready = ready[0];
  assign port2_req_ready = ready[1];
  assign port3_req_ready = ready[2];
  assign port1_valid = valid[0];
  assign port2_valid = valid[1];
  assign port3_valid = valid[2];
  assign port1_count = count_q[0];
  assign port2_count = count_q[1];
  assign port3_count = count_q[2];

  assign {port1_req_tag_in, port1_addr, port1_data_in, port1_wen} = head[0];
  assign {port2_req_tag_in, port2_addr, port2_data_in, port2_wen} = head[1];
  assign {port3_req_tag_in, port3_addr, port3_data_in, port3_wen} = head[2];

`ifdef PORT_REQUEST_STAGER_STATS_EN
  logic [15:0] stall_q;
  logic [15:0] stall_d;

  always_comb begin
    stall_d = stall_q;
    if (flush) begin
      stall_d = '0;
    end else if (freeze_inputs && (|valid) && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) stall_q <= '0;
    else          stall_q <= stall_d;
  end

  assign freeze_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_port_request_stager.sv
// tb_port_request_stager: directed stimulus with a queue scoreboard;
// a negedge monitor pops expected heads whenever the cluster captures one.
module tb_port_request_stager;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b0;
  logic freeze_inputs = 1'b0;
  logic flush = 1'b0;
  logic [2:0]  req_v = '0;
  logic [30:0] req_pkt [3];

  logic [2:0]  vld;
  logic [2:0]  rdy;
  logic [30:0] head [3];
  logic [2:0]  cnt [3];

  logic [1:0]  t1, t2, t3;
  logic [11:0] a1, a2, a3;
  logic [15:0] d1, d2, d3;
  logic        w1, w2, w3;
  logic        v1, v2, v3, r1, r2, r3;
  logic [2:0]  c1, c2, c3;
`ifdef PORT_REQUEST_STAGER_STATS_EN
  logic [15:0] stall_cnt;
`endif

  port_request_stager dut (
    .clk(clk), .reset_n(reset_n),
    .freeze_inputs(freeze_inputs), .flush(flush),
    .port1_req_valid(req_v[0]), .port1_req_ready(r1),
    .port1_req_tag(req_pkt[0][30:29]), .port1_req_addr(req_pkt[0][28:17]),
    .port1_req_data(req_pkt[0][16:1]), .port1_req_wen(req_pkt[0][0]),
    .port1_req_tag_in(t1), .port1_addr(a1), .port1_data_in(d1),
    .port1_wen(w1), .port1_valid(v1), .port1_count(c1),
    .port2_req_valid(req_v[1]), .port2_req_ready(r2),
    .port2_req_tag(req_pkt[1][30:29]), .port2_req_addr(req_pkt[1][28:17]),
    .port2_req_data(req_pkt[1][16:1]), .port2_req_wen(req_pkt[1][0]),
    .port2_req_tag_in(t2), .port2_addr(a2), .port2_data_in(d2),
    .port2_wen(w2), .port2_valid(v2), .port2_count(c2),
    .port3_req_valid(req_v[2]), .port3_req_ready(r3),
    .port3_req_tag(req_pkt[2][30:29]), .port3_req_addr(req_pkt[2][28:17]),
    .port3_req_data(req_pkt[2][16:1]), .port3_req_wen(req_pkt[2][0]),
    .port3_req_tag_in(t3), .port3_addr(a3), .port3_data_in(d3),
    .port3_wen(w3), .port3_valid(v3), .port3_count(c3)
`ifdef PORT_REQUEST_STAGER_STATS_EN
    ,
    .freeze_stall_cycles(stall_cnt)
`endif
  );

  assign vld = {v3, v2, v1};
  assign rdy = {r3, r2, r1};
  assign head[0] = {t1, a1, d1, w1};
  assign head[1] = {t2, a2, d2, w2};
  assign head[2] = {t3, a3, d3, w3};
  assign cnt[0] = c1;
  assign cnt[1] = c2;
  assign cnt[2] = c3;

  int checks = 0;
  int errors = 0;
  logic [30:0] exp_q [3][$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: a visible head in a non-frozen cycle is captured.
  always @(negedge clk) begin
    if (reset_n && !flush && !freeze_inputs) begin
      for (int p = 0; p < 3; p++) begin
        if (vld[p]) begin
          if (exp_q[p].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL p%0d_unexpected: got %h expected none",
                     p + 1, head[p]);
          end else begin
            chk($sformatf("p%0d_head", p + 1), {1'b0, head[p]},
                {1'b0, exp_q[p].pop_front()});
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [30:0] mk(input logic [1:0] t,
                                     input logic [11:0] a,
                                     input logic [15:0] d,
                                     input logic w);
    return {t, a, d, w};
  endfunction

  task automatic issue(input int p, input logic [30:0] pkt,
                       input bit expect_taken);
    req_v[p] = 1'b1;
    req_pkt[p] = pkt;
    if (expect_taken) exp_q[p].push_back(pkt);
  endtask

  task automatic idle_all();
    req_v = '0;
  endtask

  task automatic chk_empty_all(input string tag);
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("%s_p%0d_valid", tag, p + 1), {31'b0, vld[p]}, 0);
      chk($sformatf("%s_p%0d_ready", tag, p + 1), {31'b0, rdy[p]}, 1);
      chk($sformatf("%s_p%0d_count", tag, p + 1), {29'b0, cnt[p]}, 0);
      chk($sformatf("%s_p%0d_head", tag, p + 1), {1'b0, head[p]}, 0);
    end
  endtask

  logic [30:0] pk;

  initial begin
    for (int p = 0; p < 3; p++) req_pkt[p] = '0;
    // Reset state
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    chk_empty_all("reset");

    // Single request on port1, one-cycle latency
    pk = mk(2'd2, 12'h4A5, 16'hBEEF, 1'b1);
    issue(0, pk, 1);
    chk("single_no_bypass", {31'b0, v1}, 0);
    tick();
    idle_all();
    chk("single_valid", {31'b0, v1}, 1);
    chk("single_head", {1'b0, head[0]}, {1'b0, pk});
    chk("single_count", {29'b0, c1}, 1);
    tick();
    chk("single_drain_valid", {31'b0, v1}, 0);
    chk("single_drain_count", {29'b0, c1}, 0);

    // Freeze hold on port2
    freeze_inputs = 1'b1;
    issue(1, mk(2'd0, 12'h010, 16'h0000, 1'b0), 1);
    tick();
    idle_all();
    repeat (3) begin
      chk("hold_valid", {31'b0, v2}, 1);
      chk("hold_addr", {20'b0, a2}, 32'h010);
      chk("hold_count", {29'b0, c2}, 1);
      tick();
    end
    freeze_inputs = 1'b0;
    tick();
    chk("hold_release_valid", {31'b0, v2}, 0);

    // Full / backpressure on port3
    freeze_inputs = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pk = mk(2'(i), 12'(i), 16'h3000 + 16'(i), 1'b0);
      chk($sformatf("full_ready_%0d", i), {31'b0, r3}, (i < 4) ? 1 : 0);
      issue(2, pk, i < 4);
      tick();
    end
    idle_all();
    chk("full_count", {29'b0, c3}, 4);
    freeze_inputs = 1'b0;
    chk("full_ready_no_comb", {31'b0, r3}, 0);
    tick();
    chk("full_ready_after_pop", {31'b0, r3}, 1);
    chk("full_count_after_pop", {29'b0, c3}, 3);
    tick();
    tick();
    tick();
    chk("full_drained", {29'b0, c3}, 0);

    // Back-to-back stream with wrap on port1
    for (int i = 0; i < 10; i++) begin
      issue(0, mk(2'(i), 12'h100 + 12'(i), 16'hA000 + 16'(i),
                  1'(i)), 1);
      tick();
      chk($sformatf("stream_count_%0d", i), {29'b0, c1}, 1);
    end
    idle_all();
    tick();
    chk("stream_done", {29'b0, c1}, 0);

    // Flush mid-operation, then reset mid-operation
    for (int k = 0; k < 2; k++) begin
      freeze_inputs = 1'b1;
      for (int i = 0; i < 3; i++) begin
        for (int p = 0; p < 3; p++)
          issue(p, mk(2'(p), 12'h200 + 12'(i), 16'(k), 1'b1), 1);
        tick();
      end
      idle_all();
      chk($sformatf("fl%0d_count", k), {29'b0, c2}, 3);
      if (k == 0) flush = 1'b1;
      else        reset_n = 1'b0;
      issue(0, mk(2'd3, 12'hFFF, 16'hDEAD, 1'b1), 0);
      tick();
      flush = 1'b0;
      reset_n = 1'b1;
      idle_all();
      for (int p = 0; p < 3; p++) exp_q[p].delete();
      chk_empty_all($sformatf("fl%0d", k));
      freeze_inputs = 1'b0;
      tick();
      chk($sformatf("fl%0d_no_emit", k), {31'b0, v1}, 0);
    end

`ifdef PORT_REQUEST_STAGER_STATS_EN
    flush = 1'b1;
    tick();
    flush = 1'b0;
    freeze_inputs = 1'b1;
    issue(0, mk(2'd1, 12'h777, 16'h1234, 1'b0), 1);
    tick();
    idle_all();
    repeat (7) tick();
    freeze_inputs = 1'b0;
    tick();
    freeze_inputs = 1'b1;
    tick();
    tick();
    freeze_inputs = 1'b0;
    chk("stats_stall", {16'b0, stall_cnt}, 7);
`endif

    tick();
    for (int p = 0; p < 3; p++)
      chk($sformatf("sb_p%0d_left", p + 1), exp_q[p].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/port_request_stager.md
Name: port_request_stager

Overview:
- Upstream input stage for memory_banks_cluster: one independent request FIFO per port (3 ports) between the clients and the cluster's portN_* request inputs.
- The cluster zeroes its inputs while freeze_inputs=1, so any request presented in a frozen cycle is lost. This block therefore holds each request at its FIFO head until a non-frozen cycle.
- Gives clients a valid/ready handshake with backpressure.

Parameters:
- DEPTH, 4, entries per port FIFO; power of 2, minimum 2.
- PTR_W, 2, log2(DEPTH); pointer width.

Ports (N = 1, 2, 3; one set per port):
- clk  input  1  clock; all state on rising edge.
- reset_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- freeze_inputs  input  1  from cluster; 1 = the cluster ignores the request presented this cycle.
- flush  input  1  synchronous clear of all three FIFOs (in-flight requests discarded).
- portN_req_valid  input  1  client request valid.
- portN_req_ready  output  1  client may push; equals ~full.
- portN_req_tag  input  2  client tag.
- portN_req_addr  input  12  address.
- portN_req_data  input  16  write data.
- portN_req_wen  input  1  1 = write.
- portN_req_tag_in  output  2  to cluster: head tag.
- portN_addr  output  12  to cluster: head address.
- portN_data_in  output  16  to cluster: head data.
- portN_wen  output  1  to cluster: head wen.
- portN_valid  output  1  to cluster: ~empty.
- portN_count  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Each port has storage of DEPTH x 31 bits (tag, addr, data, wen), plus wr_ptr, rd_ptr (PTR_W bits each, wrap modulo DEPTH) and count (PTR_W+1 bits).
- Push = portN_req_valid & portN_req_ready. Entry written at wr_ptr; wr_ptr++ and count++.
- Pop = portN_valid & ~freeze_inputs. rd_ptr++ and count--. The cluster is deemed to have captured the head in that cycle.
- Simultaneous push and pop: both pointers advance and count is unchanged. Allowed at any occupancy where ready=1.
- Full (count=DEPTH): ready=0. A pop in the same cycle does NOT raise ready; ready is purely ~full with no combinational path from freeze_inputs.
- Empty (count=0): portN_valid=0 and all cluster-side data outputs are 0.
  - A push into an empty FIFO appears at the outputs the next cycle. Latency is 1 cycle, no bypass.
- Head outputs come combinationally from the storage entry at rd_ptr, gated to 0 when empty. They are stable while freeze_inputs=1.
- freeze_inputs is common to all ports. While it is 1, no port pops, but pushes continue until full.
- Ordering: strict FIFO per port. No ordering between ports.
- flush=1: pointers and count of all ports go to 0 next edge; any push that cycle is dropped. If flush and reset_n=0 coincide, reset takes precedence (same result).
- Reset (reset_n=0 at edge): wr_ptr=0, rd_ptr=0, count=0, stats counter (if present)=0.
  - Resulting outputs: portN_valid=0, portN_req_ready=1, data outputs=0, portN_count=0.
  - Storage array is not reset.
- Reset mid-operation: all queued requests are discarded, with no partial pop.
- Pointer wrap: wr_ptr/rd_ptr wrap DEPTH-1 -> 0 naturally. count disambiguates full vs empty.

Optional Feature:
- Macro: PORT_REQUEST_STAGER_STATS_EN.
- Defined: adds output freeze_stall_cycles (16 bits). It increments each cycle where freeze_inputs=1 and at least one portN_valid=1.
  - Saturates at 16'hFFFF.
  - Cleared by reset or flush.
- Not defined: port absent, no counter logic; all other behaviour identical.

Test Plan:
- Single request: reset; push port1 {tag=2, addr=12'h4A5, data=16'hBEEF, wen=1}, freeze=0 -> next cycle port1_valid=1 with those values; following cycle valid=0, count=0.
- Freeze hold: queue port2 read addr=12'h010; hold freeze_inputs=1 for 3 cycles -> port2_valid=1 and addr=12'h010 stable all 3 cycles, count=1. Freeze drops -> popped that cycle, valid=0 next.
- Full/backpressure: freeze=1, push 5 requests on port3 with DEPTH=4 -> ready=0 after 4th accepted, 5th not taken, count=4. Release freeze -> pops in order addr 0,1,2,3 over 4 cycles, ready=1 after first pop.
- Simultaneous push/pop with wrap: stream 10 back-to-back requests on port1, freeze=0 -> count stays 1 in steady state, outputs in order, pointers wrap, no loss.
- Flush/reset mid-operation: 3 entries queued on each port, assert flush (then repeat with reset_n=0) -> next cycle all valid=0, counts=0, ready=1; a push in the flush cycle is not emitted.
- Stats (macro defined): freeze=1 for 7 cycles with port1 non-empty, plus 2 frozen cycles with all FIFOs empty -> freeze_stall_cycles=7.
